mdu: RTL and testbench

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It sits directly downstream of the register file and forwarding muxes, and consumes the two forwarded source operands. It executes mult/multu/div/divu over a fixed multi-cycle latency and mthi/mtlo in a single cycle, holding the HI/LO architectural registers that mfhi/mflo read. It exposes `busy` so the hazard unit can stall MDU-class instructions in D.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_arith.sv | 50 +++++
 rtl/mdu.sv | 107 ++++++++++
 tb/tb_mdu.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, widths,
// default latencies and the sequencing FSM states.
package mdu_pkg;

    localparam int OP_W             = 3;
    localparam int DATA_W           = 32;
    localparam int DEF_MULT_CYCLES  = 5;
    localparam int DEF_DIV_CYCLES   = 10;

    typedef enum logic [OP_W-1:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_long_op(input logic [OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Purely combinational arithmetic for the MDU: signed/unsigned 32x32 multiply
// and divide, producing the {hi, lo} pair the sequencer will later commit.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   op,
    output logic [63:0]       result,
    output logic              div_zero
);

    logic                is_signed_div;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   dividend;
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   rem;

    // One shared unsigned divider: signed division works on magnitudes and
    // fixes signs afterwards, which also makes 0x80000000 / -1 come out as
    // 0x80000000 rem 0 without any special case.
    always_comb begin
        is_signed_div = (op == MDU_DIV);
        a_neg         = is_signed_div && A[DATA_W-1];
        b_neg         = is_signed_div && B[DATA_W-1];
        dividend      = a_neg ? -A : A;
        divisor       = b_neg ? -B : B;
        div_zero      = (B == '0) && ((op == MDU_DIV) || (op == MDU_DIVU));
        quot          = '0;
        rem           = '0;
        if (divisor != '0) begin
            quot = dividend / divisor;
            rem  = dividend % divisor;
        end
    end

    always_comb begin
        result = '0;
        case (op)
            MDU_MULT:  result = {{DATA_W{A[DATA_W-1]}}, A} * {{DATA_W{B[DATA_W-1]}}, B};
            MDU_MULTU: result = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
            MDU_DIV:   result = {a_neg ? -rem : rem, (a_neg ^ b_neg) ? -quot : quot};
            MDU_DIVU:  result = {rem, quot};
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// MIPS E-stage multiply/divide unit: holds HI/LO, runs mult/div over a fixed
// latency with busy asserted, and handles mthi/mtlo in a single cycle.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

    mdu_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   p_hi_q, p_hi_d;
    logic [DATA_W-1:0]   p_lo_q, p_lo_d;
    logic                commit_q, commit_d;
    logic [DATA_W-1:0]   hi_d, lo_d;
    logic [63:0]         arith_result;
    logic                div_zero;

    mdu_arith u_arith (
        .A        (A),
        .B        (B),
        .op       (op),
        .result   (arith_result),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            commit_q <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            commit_q <= commit_d;
            hi       <= hi_d;
            lo       <= lo_d;
        end
    end

    // A divide by zero still occupies the full latency but clears commit_q,
    // so HI/LO keep their old values when the counter expires.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        commit_d = commit_q;
        hi_d     = hi;
        lo_d     = lo;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_long_op(op)) begin
                        state_d  = ST_BUSY;
                        p_hi_d   = arith_result[63:32];
                        p_lo_d   = arith_result[31:0];
                        commit_d = !div_zero;
                        if ((op == MDU_MULT) || (op == MDU_MULTU)) begin
                            cnt_d = CNT_W'(MULT_CYCLES);
                        end else begin
                            cnt_d = CNT_W'(DIV_CYCLES);
                        end
                    end else if (op == MDU_MTHI) begin
                        hi_d = A;
                    end else if (op == MDU_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (commit_q) begin
                        hi_d = p_hi_q;
                        lo_d = p_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_BUSY);

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases with literal results plus
// randomized operations compared every cycle against a behavioural model.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    bit allow_busy_start = 1'b0;

    // Behavioural model state: remaining busy cycles and architectural HI/LO
    int          m_left   = 0;
    bit          m_commit = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;

    always #5 clk = ~clk;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    function automatic logic [63:0] refResult(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = '0;
        case (o)
            MDU_MULT:  begin sq = sa * sb; res = sq; end
            MDU_MULTU: begin uq = ua * ub; res = uq; end
            MDU_DIV:   begin sq = sa / sb; sr = sa % sb; res = {sr[31:0], sq[31:0]}; end
            MDU_DIVU:  begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
            default:   res = '0;
        endcase
        return res;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_left   <= 0;
            m_commit <= 1'b0;
            m_hi     <= '0;
            m_lo     <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_commit) begin
                m_hi <= m_phi;
                m_lo <= m_plo;
            end
        end else if (start) begin
            case (op)
                MDU_MULT, MDU_MULTU: begin
                    {m_phi, m_plo} <= refResult(op, A, B);
                    m_left   <= MC;
                    m_commit <= 1'b1;
                end
                MDU_DIV, MDU_DIVU: begin
                    if (B != 0) {m_phi, m_plo} <= refResult(op, A, B);
                    m_left   <= DC;
                    m_commit <= (B != 0);
                end
                MDU_MTHI: m_hi <= A;
                MDU_MTLO: m_lo <= A;
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("cyc_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            checkOutput("cyc_hi", hi, m_hi);
            checkOutput("cyc_lo", lo, m_lo);
        end
    end

    always @(posedge clk) begin
        if (!reset && !allow_busy_start)
            assert (!(busy && start)) else $error("[TB] start asserted while busy");
    end

    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #2;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk); #2;
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            A = $urandom;
            B = $urandom;
            @(posedge clk); #2;
        end
    endtask

    task automatic waitIdle();
        int n;
        countBusy(n);
        checkOutput("idle_within_bound", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int          n;
        int          sel;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        chk_en = 1'b1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);

        applyStimulus(MDU_MULT, 32'hFFFFFFFF, 32'd2);
        countBusy(n);
        checkOutput("mult_busy_cycles", 32'(n), 32'd5);
        checkOutput("mult_hi", hi, 32'hFFFFFFFF);
        checkOutput("mult_lo", lo, 32'hFFFFFFFE);
        checkOutput("model_mult_hi", m_hi, 32'hFFFFFFFF);

        applyStimulus(MDU_MULTU, 32'hFFFFFFFF, 32'd2);
        countBusy(n);
        checkOutput("multu_busy_cycles", 32'(n), 32'd5);
        checkOutput("multu_hi", hi, 32'h00000001);
        checkOutput("multu_lo", lo, 32'hFFFFFFFE);

        applyStimulus(MDU_DIV, 32'hFFFFFFF9, 32'd2);
        countBusy(n);
        checkOutput("div_busy_cycles", 32'(n), 32'd10);
        checkOutput("div_lo", lo, 32'hFFFFFFFD);
        checkOutput("div_hi", hi, 32'hFFFFFFFF);
        checkOutput("model_div_lo", m_lo, 32'hFFFFFFFD);

        applyStimulus(MDU_DIVU, 32'd7, 32'd2);
        countBusy(n);
        checkOutput("divu_lo", lo, 32'd3);
        checkOutput("divu_hi", hi, 32'd1);

        applyStimulus(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
        countBusy(n);
        checkOutput("ovf_lo", lo, 32'h80000000);
        checkOutput("ovf_hi", hi, 32'd0);
        checkOutput("model_ovf_lo", m_lo, 32'h80000000);

        @(posedge clk); #2;
        start = 1'b1; op = MDU_MTHI; A = 32'h12345678;
        @(posedge clk); #2;
        checkOutput("mthi_hi", hi, 32'h12345678);
        checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
        op = MDU_MTLO; A = 32'h9ABCDEF0;
        @(posedge clk); #2;
        start = 1'b0;
        checkOutput("mtlo_lo", lo, 32'h9ABCDEF0);
        checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);

        applyStimulus(MDU_DIV, 32'd5, 32'd0);
        countBusy(n);
        checkOutput("divz_busy_cycles", 32'(n), 32'd10);
        checkOutput("divz_hi", hi, 32'h12345678);
        checkOutput("divz_lo", lo, 32'h9ABCDEF0);

        // Reset in the fourth busy cycle must discard the pending quotient
        applyStimulus(MDU_DIVU, 32'd100, 32'd7);
        repeat (3) begin @(posedge clk); #2; end
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_mid_hi", hi, 32'd0);
        checkOutput("rst_mid_lo", lo, 32'd0);
        repeat (12) begin @(posedge clk); #2; end
        checkOutput("rst_no_commit_hi", hi, 32'd0);
        checkOutput("rst_no_commit_lo", lo, 32'd0);

        applyStimulus(MDU_MULT, 32'd3, 32'd4);
        allow_busy_start = 1'b1;
        start = 1'b1; op = MDU_DIV; A = 32'd100; B = 32'd7;
        @(posedge clk); #2;
        start = 1'b0;
        allow_busy_start = 1'b0;
        countBusy(n);
        checkOutput("ign_busy_cycles", 32'(n), 32'd4);
        checkOutput("ign_hi", hi, 32'd0);
        checkOutput("ign_lo", lo, 32'd12);

        for (int i = 0; i < 300; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 17));
            else if (sel == 3 && rb[31]) ra = {1'b1, ra[30:0]};
            applyStimulus(rop, ra, rb);
            waitIdle();
        end

        @(posedge clk); #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
